// File: rtl/rand_roll_ctrl_pkg.sv
// Shared definitions for the random-roll display sequencer.
// The state encoding is also what appears on the LEDR status output.
package rand_roll_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ROLL = 2'b01,
      ST_HOLD = 2'b10
   } roll_state_t;

   // Returns the counter width needed to hold values 0..max_val.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/rand_roll_ctrl_rise_detect.sv
// One-bit rising-edge detector with a registered single-cycle pulse output.
// RST_VAL is the assumed previous level at reset release, so a level that is
// already high when reset drops does not count as an edge.
module rand_roll_ctrl_rise_detect #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_pulse
);

   logic r_prev;
   logic r_pulse;

   // Track the previous level and register a pulse on a 0->1 transition.
   // NOTE: sequential state uses non-blocking assignments so r_prev still holds
   // the old level while r_pulse is computed in the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prev  <= RST_VAL;
         r_pulse <= 1'b0;
      end else begin
         r_prev  <= i_d;
         r_pulse <= i_d & ~r_prev;
      end
   end

   assign o_pulse = r_pulse;

endmodule

// File: rtl/rand_roll_ctrl.sv
// Random-number display sequencer.
// On a start request the display "rolls", copying the free-running LFSR word
// on slow ticks, then freezes on a final value after ROLL_UPDATES captures.
// Optional feature macro: RAND_ROLL_SLOWDOWN_EN -- the tick interval between
// captures doubles after each capture (saturating at 2**(IVL_W-1)), so the
// display visibly decelerates. Without it every tick captures.
module rand_roll_ctrl
   import rand_roll_ctrl_pkg::*;
#(
   parameter int WIDTH        = 15,
   parameter int ROLL_UPDATES = 16,
   parameter int IVL_W        = 4
) (
   input  logic             ADC_CLK_10,
   input  logic             rst,
   input  logic             tick_in,
   input  logic             start,
   input  logic             clear,
   input  logic [WIDTH-1:0] rand_in,
   output logic [WIDTH-1:0] disp_val,
   output logic             disp_valid,
   output logic             busy,
   output logic [1:0]       state_o
);

   localparam int                 UPD_W       = cnt_width(ROLL_UPDATES);
   localparam logic [UPD_W-1:0]   LP_UPD_ONE  = UPD_W'(1);
   localparam logic [UPD_W-1:0]   LP_UPD_LAST = UPD_W'(ROLL_UPDATES - 1);
   localparam logic [IVL_W-1:0]   LP_IVL_ONE  = IVL_W'(1);
`ifdef RAND_ROLL_SLOWDOWN_EN
   localparam logic [IVL_W-1:0]   LP_IVL_MAX  = IVL_W'(1) << (IVL_W - 1);
`endif

   roll_state_t      r_state;
   logic [WIDTH-1:0] r_disp_val;
   logic             r_disp_valid;
   logic             r_busy;
   logic [IVL_W-1:0] r_tick_cnt;
   logic [UPD_W-1:0] r_upd_cnt;
   logic [IVL_W-1:0] w_interval;

   logic             r_sync1;
   logic             r_sync2;
   logic             w_start_p;
   logic             w_tick_p;

`ifdef RAND_ROLL_SLOWDOWN_EN
   logic [IVL_W-1:0] r_interval;
   assign w_interval = r_interval;
`else
   assign w_interval = LP_IVL_ONE;
`endif

   // Two-flop synchroniser for the raw switch level.
   // NOTE: these reset to 1 rather than 0 so a switch already high at reset
   // release does not ripple through as a fake rising edge.
   always_ff @(posedge ADC_CLK_10 or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= start;
         r_sync2 <= r_sync1;
      end
   end

   rand_roll_ctrl_rise_detect #(.RST_VAL(1'b1)) u_start_edge (
      .clk     (ADC_CLK_10),
      .rst     (rst),
      .i_d     (r_sync2),
      .o_pulse (w_start_p)
   );

   rand_roll_ctrl_rise_detect #(.RST_VAL(1'b1)) u_tick_edge (
      .clk     (ADC_CLK_10),
      .rst     (rst),
      .i_d     (tick_in),
      .o_pulse (w_tick_p)
   );

   // Roll sequencer: state, counters and registered status outputs together.
   always_ff @(posedge ADC_CLK_10 or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_disp_val   <= '0;
         r_disp_valid <= 1'b0;
         r_busy       <= 1'b0;
         r_tick_cnt   <= '0;
         r_upd_cnt    <= '0;
`ifdef RAND_ROLL_SLOWDOWN_EN
         r_interval   <= LP_IVL_ONE;
`endif
      end else if (clear) begin
         // Clear wins over any start or tick pulse in the same cycle.
         r_state      <= ST_IDLE;
         r_disp_val   <= '0;
         r_disp_valid <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_HOLD: begin
               if (w_start_p) begin
                  r_state      <= ST_ROLL;
                  r_disp_valid <= 1'b0;
                  r_busy       <= 1'b1;
                  r_tick_cnt   <= '0;
                  r_upd_cnt    <= '0;
`ifdef RAND_ROLL_SLOWDOWN_EN
                  r_interval   <= LP_IVL_ONE;
`endif
               end
            end
            ST_ROLL: begin
               if (w_tick_p) begin
                  if (r_tick_cnt == w_interval - LP_IVL_ONE) begin
                     r_disp_val <= rand_in;
                     r_tick_cnt <= '0;
                     r_upd_cnt  <= r_upd_cnt + LP_UPD_ONE;
`ifdef RAND_ROLL_SLOWDOWN_EN
                     if (r_interval < LP_IVL_MAX)
                        r_interval <= r_interval << 1;
`endif
                     if (r_upd_cnt == LP_UPD_LAST) begin
                        r_state      <= ST_HOLD;
                        r_busy       <= 1'b0;
                        r_disp_valid <= 1'b1;
                     end
                  end else begin
                     r_tick_cnt <= r_tick_cnt + LP_IVL_ONE;
                  end
               end
            end
            default: begin
               // Unused encoding: recover to a clean idle.
               r_state      <= ST_IDLE;
               r_disp_valid <= 1'b0;
               r_busy       <= 1'b0;
            end
         endcase
      end
   end

   assign disp_val   = r_disp_val;
   assign disp_valid = r_disp_valid;
   assign busy       = r_busy;
   assign state_o    = r_state;

endmodule

// File: tb/tb_rand_roll_ctrl.sv
// Self-checking bench for rand_roll_ctrl: directed scenarios followed by
// randomized stimulus, all compared against a behavioural model that tracks
// roll progress as "ticks since start" against a list of capture points.
module tb_rand_roll_ctrl;

   localparam int WIDTH = 15;
   localparam int RU    = 4;
   localparam int IVL_W = 4;
   localparam int M_IDLE = 0;
   localparam int M_ROLL = 1;
   localparam int M_HOLD = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             tick_in;
   logic             start;
   logic             clear;
   logic [WIDTH-1:0] rand_in;
   logic [WIDTH-1:0] disp_val;
   logic             disp_valid;
   logic             busy;
   logic [1:0]       state_o;

   int n_cmp = 0;
   int n_err = 0;

   // Model state
   int               m_mode;
   logic [WIDTH-1:0] m_disp;
   int               m_ticks, m_caps, m_next, m_ivl;
   logic             m_s1, m_s2, m_s3, m_s4;   // start samples, 1..4 edges ago
   logic             m_t1, m_t2;               // tick samples, 1..2 edges ago

   always #5 clk = ~clk;

   rand_roll_ctrl #(.WIDTH(WIDTH), .ROLL_UPDATES(RU), .IVL_W(IVL_W)) dut (
      .ADC_CLK_10 (clk),
      .rst        (rst),
      .tick_in    (tick_in),
      .start      (start),
      .clear      (clear),
      .rand_in    (rand_in),
      .disp_val   (disp_val),
      .disp_valid (disp_valid),
      .busy       (busy),
      .state_o    (state_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE;
      m_disp = '0;
      m_ticks = 0; m_caps = 0; m_next = 1; m_ivl = 1;
      m_s1 = 1'b1; m_s2 = 1'b1; m_s3 = 1'b1; m_s4 = 1'b1;
      m_t1 = 1'b1; m_t2 = 1'b1;
   endtask

   // One clock edge of behaviour, using the inputs the DUT just sampled.
   // The switch edge becomes effective three edges after it is sampled;
   // the tick edge one edge after it is sampled.
   task automatic model_edge();
      logic sp, tp;
      sp = m_s3 & ~m_s4;
      tp = m_t1 & ~m_t2;
      if (clear) begin
         m_mode = M_IDLE;
         m_disp = '0;
      end else if (m_mode == M_ROLL) begin
         if (tp) begin
            m_ticks++;
            if (m_ticks == m_next) begin
               m_disp = rand_in;
               m_caps++;
`ifdef RAND_ROLL_SLOWDOWN_EN
               if (m_ivl < (1 << (IVL_W - 1))) m_ivl = m_ivl * 2;
`endif
               m_next = m_next + m_ivl;
               if (m_caps == RU) m_mode = M_HOLD;
            end
         end
      end else if (sp) begin
         m_mode = M_ROLL;
         m_ticks = 0; m_caps = 0; m_ivl = 1; m_next = 1;
      end
      m_s4 = m_s3; m_s3 = m_s2; m_s2 = m_s1; m_s1 = start;
      m_t2 = m_t1; m_t1 = tick_in;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".state"}, 32'(state_o), 32'(m_mode));
      check({tag, ".disp"},  32'(disp_val), 32'(m_disp));
      check({tag, ".valid"}, 32'(disp_valid), 32'(m_mode == M_HOLD));
      check({tag, ".busy"},  32'(busy), 32'(m_mode == M_ROLL));
   endtask

   task automatic step(input string tag, input logic s, input logic t,
                       input logic c, input logic [WIDTH-1:0] r);
      @(negedge clk);
      start = s; tick_in = t; clear = c; rand_in = r;
      @(posedge clk);
      model_edge();
      #1 check_all(tag);
   endtask

   // One slow tick period: level high for two cycles, low for two.
   task automatic tick_period(input string tag, input logic s, input logic [WIDTH-1:0] r);
      step(tag, s, 1'b1, 1'b0, r);
      step(tag, s, 1'b1, 1'b0, r);
      step(tag, s, 1'b0, 1'b0, r);
      step(tag, s, 1'b0, 1'b0, r);
   endtask

   task automatic apply_reset(input logic s);
      @(negedge clk);
      rst = 1'b1; start = s; tick_in = 1'b0; clear = 1'b0;
      model_reset();
      repeat (2) begin
         @(posedge clk);
         #1 check_all("reset");
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int exp_final;
      int hp, ph;
      logic s_lvl, t_lvl;

`ifdef RAND_ROLL_SLOWDOWN_EN
      exp_final = 15;
`else
      exp_final = RU;
`endif

      // 1: reset with start held high -> no roll until start drops and rises
      rst = 1'b1; start = 1'b1; tick_in = 1'b0; clear = 1'b0; rand_in = '0;
      model_reset();
      #1 check_all("t1_rst0");
      apply_reset(1'b1);
      for (int i = 0; i < 10; i++) step("t1_hold", 1'b1, i[1], 1'b0, 15'h7abc);
      check("t1_idle", 32'(state_o), 32'd0);
      check("t1_busy", 32'(busy), 32'd0);
      repeat (3) step("t1_low", 1'b0, 1'b0, 1'b0, 15'h0);

      // 2: rand stepped per tick -> captures, then HOLD
      repeat (4) step("t2_start", 1'b1, 1'b0, 1'b0, 15'h0);
      check("t2_busy", 32'(busy), 32'd1);
      for (int k = 1; k <= 16; k++) tick_period("t2_tick", 1'b1, WIDTH'(k));
      check("t2_final", 32'(disp_val), 32'(exp_final));
      check("t2_valid", 32'(disp_valid), 32'd1);
      check("t2_state", 32'(state_o), 32'd2);

      // 4: start edge in ROLL ignored, start edge in HOLD restarts
      repeat (4) step("t4_low", 1'b0, 1'b0, 1'b0, 15'h0);
      repeat (4) step("t4_start", 1'b1, 1'b0, 1'b0, 15'h0);
      for (int k = 0; k < 16; k++)
         tick_period("t4_tick", (k < 8) ? k[0] : 1'b1, WIDTH'(100 + k));
      check("t4_hold", 32'(state_o), 32'd2);
      repeat (4) step("t4_low2", 1'b0, 1'b0, 1'b0, 15'h0);
      repeat (4) step("t4_restart", 1'b1, 1'b0, 1'b0, 15'h0);
      check("t4_busy", 32'(busy), 32'd1);
      tick_period("t4_cap", 1'b1, 15'h1234);

      // 5: clear coinciding with the tick pulse -> IDLE, zero, no capture
      step("t5_pre", 1'b1, 1'b0, 1'b0, 15'h0);
      step("t5_rise", 1'b1, 1'b1, 1'b0, 15'h5555);
      step("t5_clr", 1'b1, 1'b1, 1'b1, 15'h5555);
      check("t5_disp", 32'(disp_val), 32'd0);
      check("t5_state", 32'(state_o), 32'd0);
      repeat (3) step("t5_post", 1'b1, 1'b0, 1'b0, 15'h0);

      // 6: reset asserted between edges mid-roll -> outputs zero immediately
      repeat (4) step("t6_low", 1'b0, 1'b0, 1'b0, 15'h0);
      repeat (4) step("t6_start", 1'b1, 1'b0, 1'b0, 15'h0);
      tick_period("t6_tick", 1'b1, 15'h2bcd);
      step("t6_rise", 1'b1, 1'b1, 1'b0, 15'h3333);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("t6_disp", 32'(disp_val), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_state", 32'(state_o), 32'd0);
      check("t6_valid", 32'(disp_valid), 32'd0);
      apply_reset(1'b0);

      // Randomized phase
      s_lvl = 1'b0; t_lvl = 1'b0; hp = 2; ph = 0;
      for (int i = 0; i < 1500; i++) begin
         logic c;
         if (++ph >= hp) begin
            ph = 0;
            t_lvl = ~t_lvl;
            hp = int'($urandom_range(1, 4));
         end
         if ($urandom_range(0, 11) == 0) s_lvl = ~s_lvl;
         c = ($urandom_range(0, 59) == 0);
         step("rnd", s_lvl, t_lvl, c, WIDTH'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
